// File: rtl/fetch_queue.sv
// Instruction fetch stage with an in-order decoupling queue feeding decode.
// Optional zero-latency response-to-decode bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [31:0]              mem_req_addr,
    input  logic                     mem_resp_valid,
    input  logic [31:0]              mem_resp_inst,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [31:0]              dec_inst,
    output logic [31:0]              dec_pc,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [31:0]      entry_pc   [DEPTH];
    logic [31:0]      entry_inst [DEPTH];
    logic [DEPTH-1:0] entry_filled;

    logic [PTR_W-1:0] wr_ptr, fill_ptr, rd_ptr;
    logic [PTR_W-1:0] inflight, drop_cnt;
    logic [PTR_W-1:0] occ;

    logic [IDX_W-1:0] wr_idx, fill_idx, rd_idx;
    logic             req_fire, deq_fire, resp_keep;
    logic             head_nonempty, head_filled;
    logic             bypass_hit, bypass_take;
    logic [PTR_W-1:0] req_inc, resp_dec;

    assign wr_idx   = wr_ptr[IDX_W-1:0];
    assign fill_idx = fill_ptr[IDX_W-1:0];
    assign rd_idx   = rd_ptr[IDX_W-1:0];

    assign occ       = wr_ptr - rd_ptr;
    assign occupancy = occ;

    assign mem_req_valid = reset_n && (occ < DEPTH_P) && (inflight < DEPTH_P) && !redirect_valid;
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign head_nonempty = (rd_ptr != wr_ptr);
    assign head_filled   = entry_filled[rd_idx];

`ifdef FETCH_QUEUE_BYPASS_EN
    // A pending head is necessarily the next slot to fill, so a kept response lands on it.
    assign bypass_hit = head_nonempty && !head_filled && (drop_cnt == '0)
                        && mem_resp_valid && !redirect_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    assign dec_valid   = !redirect_valid && head_nonempty && (head_filled || bypass_hit);
    assign dec_inst    = bypass_hit ? mem_resp_inst : entry_inst[rd_idx];
    assign dec_pc      = entry_pc[rd_idx];
    assign deq_fire    = dec_valid && dec_ready;
    assign bypass_take = bypass_hit && dec_ready;

    assign resp_keep = mem_resp_valid && (drop_cnt == '0) && !redirect_valid;
    assign req_inc   = req_fire ? ONE : '0;
    assign resp_dec  = mem_resp_valid ? ONE : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc     <= RESET_PC;
            wr_ptr       <= '0;
            fill_ptr     <= '0;
            rd_ptr       <= '0;
            inflight     <= '0;
            drop_cnt     <= '0;
            entry_filled <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_pc[i]   <= '0;
                entry_inst[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Every request still outstanding after this edge belongs to the old stream.
            wr_ptr       <= '0;
            fill_ptr     <= '0;
            rd_ptr       <= '0;
            entry_filled <= '0;
            fetch_pc     <= redirect_pc;
            inflight     <= inflight - resp_dec;
            drop_cnt     <= inflight - resp_dec;
        end else begin
            inflight <= inflight + req_inc - resp_dec;
            if (mem_resp_valid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - ONE;

            if (deq_fire) begin
                entry_filled[rd_idx] <= 1'b0;
                rd_ptr               <= rd_ptr + ONE;
            end

            if (resp_keep) begin
                fill_ptr <= fill_ptr + ONE;
                if (!bypass_take) begin
                    entry_inst[fill_idx]   <= mem_resp_inst;
                    entry_filled[fill_idx] <= 1'b1;
                end
            end

            if (req_fire) begin
                entry_pc[wr_idx]     <= fetch_pc;
                entry_filled[wr_idx] <= 1'b0;
                wr_ptr               <= wr_ptr + ONE;
                fetch_pc             <= fetch_pc + 32'd4;
            end
        end
    end

endmodule
